// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter and sequencer that lets two requesters
// share one external ALU. A granted command drives the ALU operands for LAT
// cycles. The result and error are then captured and returned with a done
// pulse to the requester that was granted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/req1                command requests
//   a0,b0,mode0,op0          requester 0 operands / mode / opcode
//   a1,b1,mode1,op1          requester 1 operands / mode / opcode
//   ack0/ack1                one-cycle pulse: command accepted
//   done0/done1              one-cycle pulse: res_out/err_out valid
//   res_out, err_out         latched ALU result and error
//   alu_a,alu_b,alu_mode,alu_op  registered drive to the shared ALU
//   alu_res, alu_err         shared ALU result and error
//   busy                     high whenever the FSM is not idle
//   err_cnt                  saturating count of captured errors; this port
//                            exists only when ALU_SCHED_ERRCNT_EN is defined
module alu_scheduler #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res_out,
  output logic        err_out,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_mode,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_err,
`ifdef ALU_SCHED_ERRCNT_EN
  output logic        busy,
  output logic [7:0]  err_cnt
`else
  output logic        busy
`endif
);

  localparam int unsigned CW = 4;
  localparam int unsigned EW = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nx;
  logic          ptr, ptr_nx;     // 1: requester 1 has priority on a tie
  logic          gnt, gnt_nx;     // requester that owns the current command
  logic [CW-1:0] cnt, cnt_nx;
  logic          ack0_nx, ack1_nx, done0_nx, done1_nx, busy_nx;
  logic [31:0]   res_nx;
  logic          err_nx;
  logic [15:0]   alu_a_nx, alu_b_nx;
  logic          alu_mode_nx;
  logic [1:0]    alu_op_nx;
  logic          win1;
  logic          cap;
`ifdef ALU_SCHED_ERRCNT_EN
  logic [EW-1:0] err_cnt_nx;
`endif

  // Next-state, arbitration and registered-output values.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    gnt_nx      = gnt;
    cnt_nx      = cnt;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    done0_nx    = 1'b0;
    done1_nx    = 1'b0;
    res_nx      = res_out;
    err_nx      = err_out;
    alu_a_nx    = alu_a;
    alu_b_nx    = alu_b;
    alu_mode_nx = alu_mode;
    alu_op_nx   = alu_op;
    win1        = 1'b0;
    cap         = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // A lone requester always wins; on a tie the pointer decides.
          win1        = req1 && (!req0 || ptr);
          ptr_nx      = !win1;
          gnt_nx      = win1;
          ack0_nx     = !win1;
          ack1_nx     = win1;
          alu_a_nx    = win1 ? a1 : a0;
          alu_b_nx    = win1 ? b1 : b0;
          alu_mode_nx = win1 ? mode1 : mode0;
          alu_op_nx   = win1 ? op1 : op0;
          cnt_nx      = CW'(LAT);
          state_nx    = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CW'(1)) begin
          cap      = 1'b1;
          res_nx   = alu_res;
          err_nx   = alu_err;
          done0_nx = !gnt;
          done1_nx = gnt;
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
`ifdef ALU_SCHED_ERRCNT_EN
    err_cnt_nx = err_cnt;
    if (cap && alu_err && (err_cnt != {EW{1'b1}}))
      err_cnt_nx = err_cnt + EW'(1);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      res_out  <= '0;
      err_out  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_mode <= 1'b0;
      alu_op   <= '0;
      busy     <= 1'b0;
`ifdef ALU_SCHED_ERRCNT_EN
      err_cnt  <= '0;
`endif
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gnt      <= gnt_nx;
      cnt      <= cnt_nx;
      ack0     <= ack0_nx;
      ack1     <= ack1_nx;
      done0    <= done0_nx;
      done1    <= done1_nx;
      res_out  <= res_nx;
      err_out  <= err_nx;
      alu_a    <= alu_a_nx;
      alu_b    <= alu_b_nx;
      alu_mode <= alu_mode_nx;
      alu_op   <= alu_op_nx;
      busy     <= busy_nx;
`ifdef ALU_SCHED_ERRCNT_EN
      err_cnt  <= err_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler: one instance with LAT=1
// and one with LAT=3, both driven by the same stimulus.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, mode0, mode1, alu_err;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  op0, op1;
  logic [31:0] alu_res;

  logic        p_ack0, p_ack1, p_done0, p_done1, p_err_out, p_alu_mode, p_busy;
  logic [31:0] p_res_out;
  logic [15:0] p_alu_a, p_alu_b;
  logic [1:0]  p_alu_op;
  logic        q_ack0, q_ack1, q_done0, q_done1, q_err_out, q_alu_mode, q_busy;
  logic [31:0] q_res_out;
  logic [15:0] q_alu_a, q_alu_b;
  logic [1:0]  q_alu_op;
`ifdef ALU_SCHED_ERRCNT_EN
  logic [7:0]  p_err_cnt, q_err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.LAT(1)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .mode0(mode0), .mode1(mode1), .op0(op0), .op1(op1),
    .ack0(p_ack0), .ack1(p_ack1), .done0(p_done0), .done1(p_done1),
    .res_out(p_res_out), .err_out(p_err_out),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_mode(p_alu_mode), .alu_op(p_alu_op),
    .alu_res(alu_res), .alu_err(alu_err),
`ifdef ALU_SCHED_ERRCNT_EN
    .busy(p_busy), .err_cnt(p_err_cnt)
`else
    .busy(p_busy)
`endif
  );

  alu_scheduler #(.LAT(3)) u3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .mode0(mode0), .mode1(mode1), .op0(op0), .op1(op1),
    .ack0(q_ack0), .ack1(q_ack1), .done0(q_done0), .done1(q_done1),
    .res_out(q_res_out), .err_out(q_err_out),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_mode(q_alu_mode), .alu_op(q_alu_op),
    .alu_res(alu_res), .alu_err(alu_err),
`ifdef ALU_SCHED_ERRCNT_EN
    .busy(q_busy), .err_cnt(q_err_cnt)
`else
    .busy(q_busy)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    int na, nd;
    logic [3:0] ack_ord, done_ord;
    logic [15:0] ack_a [4];

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    mode0 = 1'b0; mode1 = 1'b0; op0 = '0; op1 = '0;
    alu_res = '0; alu_err = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_busy", 32'(p_busy), 32'd0);
    check("rst_acks", 32'({p_ack0, p_ack1, p_done0, p_done1}), 32'd0);
    check("rst_res", p_res_out, 32'd0);
    check("rst_err", 32'(p_err_out), 32'd0);
    check("rst_alu", {p_alu_a, p_alu_b}, 32'd0);
    check("rst_alu_mo", 32'({p_alu_mode, p_alu_op}), 32'd0);
`ifdef ALU_SCHED_ERRCNT_EN
    check("rst_errcnt", 32'(p_err_cnt), 32'd0);
`endif

    // Single command, LAT=1: 7+5 returned as 12
    rst = 1'b0; req0 = 1'b1; a0 = 16'd7; b0 = 16'd5; mode0 = 1'b1; op0 = 2'd0;
    alu_res = 32'd12; alu_err = 1'b0;
    tick();
    check("t1_ack0", 32'({p_ack0, p_ack1}), 32'b10);
    check("t1_alu_ab", {p_alu_a, p_alu_b}, {16'd7, 16'd5});
    check("t1_alu_mo", 32'({p_alu_mode, p_alu_op}), 32'b100);
    check("t1_busy", 32'(p_busy), 32'd1);
    check("t1_nodone", 32'({p_done0, p_done1}), 32'd0);
    req0 = 1'b0;
    tick();
    check("t1_done0", 32'({p_ack0, p_done0, p_done1}), 32'b010);
    check("t1_res", p_res_out, 32'd12);
    check("t1_err", 32'(p_err_out), 32'd0);
    check("t1_hold_a", 32'(p_alu_a), 32'd7);
    tick();
    check("t1_idle", 32'({p_done0, p_busy}), 32'd0);
    check("t1_res_hold", p_res_out, 32'd12);

    // Both requesting continuously: grants alternate, 4 done in 12 cycles
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; a0 = 16'd1; a1 = 16'd2;
    na = 0; nd = 0; ack_ord = '0; done_ord = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("t2_ack_excl", 32'(p_ack0 && p_ack1), 32'd0);
      check("t2_done_excl", 32'(p_done0 && p_done1), 32'd0);
      if ((p_ack0 || p_ack1) && na < 4) begin
        ack_ord[na] = p_ack1; ack_a[na] = p_alu_a; na++;
      end
      if ((p_done0 || p_done1) && nd < 4) begin
        done_ord[nd] = p_done1; nd++;
      end
    end
    check("t2_nack", 32'(na), 32'd4);
    check("t2_ndone", 32'(nd), 32'd4);
    check("t2_ack_ord", 32'(ack_ord), 32'b1010);
    check("t2_done_ord", 32'(done_ord), 32'b1010);
    check("t2_alu_a", {ack_a[0], ack_a[1]}, {16'd1, 16'd2});
    check("t2_alu_a2", {ack_a[2], ack_a[3]}, {16'd1, 16'd2});
    req0 = 1'b0; req1 = 1'b0;

    // LAT=3, requester 1, ALU signals error
    rst = 1'b1; tick();
    rst = 1'b0; req1 = 1'b1; a1 = 16'd9; b1 = 16'd0; mode1 = 1'b1; op1 = 2'd3;
    alu_res = 32'h0000_dead; alu_err = 1'b1;
    tick();
    check("t3_ack1", 32'({q_ack0, q_ack1}), 32'b01);
    check("t3_alu_mo", 32'({q_alu_mode, q_alu_op}), 32'b111);
    check("t3_alu_b", 32'(q_alu_b), 32'd0);
    req1 = 1'b0;
    tick();
    check("t3_exec2", 32'({q_done1, q_busy}), 32'b01);
    tick();
    check("t3_exec3", 32'({q_done1, q_busy}), 32'b01);
    tick();
    check("t3_done1", 32'({q_done0, q_done1}), 32'b01);
    check("t3_err", 32'(q_err_out), 32'd1);
    check("t3_res", q_res_out, 32'h0000_dead);
    check("t3_hold_a", 32'(q_alu_a), 32'd9);
`ifdef ALU_SCHED_ERRCNT_EN
    check("t3_errcnt", 32'(q_err_cnt), 32'd1);
`endif
    tick();

    // Reset mid-EXEC on LAT=3 discards the command and resets the pointer
    alu_err = 1'b0; req0 = 1'b1; a0 = 16'd3;
    tick();
    check("t4_ack0", 32'(q_ack0), 32'd1);
    req0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t4_busy", 32'(q_busy), 32'd0);
    check("t4_res", q_res_out, 32'd0);
    check("t4_err", 32'(q_err_out), 32'd0);
    check("t4_alu_a", 32'(q_alu_a), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t4_nodone", 32'({q_done0, q_done1}), 32'd0);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("t4_ptr0", 32'({q_ack0, q_ack1}), 32'b10);
    req0 = 1'b0; req1 = 1'b0;

    // Request 1 during requester 0's command waits for IDLE
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; a0 = 16'd4; a1 = 16'd6;
    tick();
    check("t5_ack0", 32'({p_ack0, p_ack1}), 32'b10);
    req0 = 1'b0; req1 = 1'b1;
    tick();
    check("t5_done0", 32'({p_ack1, p_done0}), 32'b01);
    tick();
    check("t5_idle", 32'({p_ack1, p_busy}), 32'd0);
    tick();
    check("t5_ack1", 32'({p_ack0, p_ack1}), 32'b01);
    check("t5_alu_a", 32'(p_alu_a), 32'd6);
    req1 = 1'b0;

`ifdef ALU_SCHED_ERRCNT_EN
    // 256 error commands saturate the counter at 255
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; alu_err = 1'b1;
    repeat (256 * 3) tick();
    req0 = 1'b0;
    tick(); tick(); tick();
    check("t6_errcnt_sat", 32'(p_err_cnt), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
